cnn_mul_share_arb: RTL and testbench
====================================

Name: cnn_mul_share_arb

Overview:
- Time-shares one signed 14-bit × signed 8-bit multiplier among NUM_REQ requesters, e.g. conv2 PE lanes whose combined issue rate stays below one product per cycle.
- Uses round-robin arbitration, a 2-stage pipeline (operand register, product register) and a tagged result port with backpressure.
- Sits between the conv lane controllers and the shared DSP48 multiplier slice.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester tag; must satisfy 2**ID_W >= NUM_REQ.
- A_W, 14, operand A width, signed.
- B_W, 8, operand B width, signed.
- P_W, 22, product width; fixed at A_W+B_W.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  reset; synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_a  in  NUM_REQ*A_W  packed operand A; requester i occupies bits [i*A_W +: A_W].
- req_b  in  NUM_REQ*B_W  packed operand B; requester i occupies bits [i*B_W +: B_W].
- req_ready  out  NUM_REQ  one-hot grant; a transfer happens when req_valid[i] && req_ready[i].
- res_valid  out  1  product valid.
- res_id  out  ID_W  index of the requester that owns res_p.
- res_p  out  P_W  signed product.
- res_ready  in  1  downstream accepts the result.

Behaviour:
- Reset: ap_rst high at a clock edge clears rr_ptr to 0 and clears s1_valid and s2_valid. Consequences:
  - res_valid = 0 and req_ready = 0 in the following cycle.
  - res_p and res_id read as 0 while res_valid = 0.
  - Reset mid-operation discards all in-flight products without emitting them.
- Stall condition: stall = s2_valid && !res_ready.
- Stage advance rule: s2 loads from s1 whenever !stall. s1 loads a new grant, or a bubble, whenever !stall.
- Arbitration (combinational):
  - When !stall, grant g = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready = onehot(g). If no request is valid, req_ready = 0.
  - When stall, req_ready = 0.
  - req_ready may depend combinationally on req_valid. req_valid must not depend on req_ready.
- On a grant:
  - s1 captures a, b and id = g.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - rr_ptr is unchanged when there is no grant.
- Stage 2: s2_p <= signed(s1_a) * signed(s1_b), a full 22-bit result with no truncation or overflow. s2_id <= s1_id.
- Outputs: res_valid = s2_valid, res_id = s2_id, res_p = s2_p.
- Latency and throughput:
  - A grant at edge T gives res_valid in the cycle after edge T+1 (2-cycle latency).
  - Throughput is 1 product/cycle when res_ready stays high.
- Stall behaviour:
  - s1 and s2 contents and rr_ptr hold.
  - res_valid, res_id and res_p stay stable until res_ready.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0,… Any valid requester waits at most NUM_REQ-1 grants.
- Ordering: results leave in grant order; there is no reordering.
- Extreme operands: -8192 × -128 = 1048576 fits in 22 bits signed and must be exact.

Optional Feature:
- Macro: CNN_MUL_SHARE_ARB_PRIO_EN.
- Defined:
  - Adds input prio_req (1 bit) and parameter PRIO_IDX (default 0).
  - While prio_req && req_valid[PRIO_IDX] && !stall, requester PRIO_IDX is granted regardless of rr_ptr.
  - rr_ptr is not updated on a priority grant.
- Undefined: the prio_req port does not exist and arbitration is pure round-robin.

Decomposition:
- Package cnn_mul_share_pkg holds constants A_W=14, B_W=8, P_W=22 and a function rr_pick(valid, ptr) returning the grant index plus a found flag.
- Natural sub-module: cnn_mul_share_dsp, the registered multiply stage (s1 → s2 with enable). It maps to one DSP48 with AREG/PREG.

Test Plan:
- Single request: req0 valid with a=100, b=-3 → req_ready[0]=1 that cycle; two cycles later res_valid=1, res_id=0, res_p=-300.
- All four requesters valid every cycle, res_ready=1 → grant order 0,1,2,3,0,…; one result per cycle with matching ids.
- Extremes: (-8192,-128) → 1048576; (8191,127) → 1040257; (-8192,127) → -1040384.
- Hold res_ready=0 for 5 cycles with results in flight → req_ready=0; res_valid, res_p and res_id stable. After release, every result arrives exactly once, in order.
- ap_rst asserted with two products in flight → the next cycle has res_valid=0 and rr_ptr=0; the first grant after reset goes to the lowest valid index.
- With CNN_MUL_SHARE_ARB_PRIO_EN, PRIO_IDX=2, prio_req=1 and all requesters valid → requester 2 granted every cycle; after prio_req drops, round-robin resumes from the pre-priority rr_ptr.

Source files
------------

// File: rtl/cnn_mul_share_pkg.sv
// Shared constants and the round-robin pick helper for cnn_mul_share_arb.
// Optional feature macro: CNN_MUL_SHARE_ARB_PRIO_EN (fixed-index priority grant).
package cnn_mul_share_pkg;

  localparam int A_W     = 14;
  localparam int B_W     = 8;
  localparam int P_W     = A_W + B_W;
  localparam int MAX_REQ = 8;
  localparam int PICK_W  = 3;

  typedef struct packed {
    logic              found;
    logic [PICK_W-1:0] idx;
  } pick_t;

  // First valid requester scanning ptr, ptr+1, ... modulo n (n <= MAX_REQ, ptr < n).
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [PICK_W-1:0]  ptr,
                                    input int                 n);
    pick_t r;
    int    j;
    r = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && !r.found && valid[j[PICK_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = j[PICK_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cnn_mul_share_arb_if.sv
// Request/result bus of the shared multiplier.
// Optional feature macro: CNN_MUL_SHARE_ARB_PRIO_EN adds prio_req.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high. req_ready may depend combinationally on req_valid, never the reverse.
// res_valid/res_id/res_p hold steady until res_ready is seen.
interface cnn_mul_share_arb_if
  import cnn_mul_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   res_valid;
  logic [ID_W-1:0]        res_id;
  logic [P_W-1:0]         res_p;
  logic                   res_ready;
`ifdef CNN_MUL_SHARE_ARB_PRIO_EN
  logic                   prio_req;
`endif

  modport master (
    output req_valid, req_a, req_b, res_ready,
`ifdef CNN_MUL_SHARE_ARB_PRIO_EN
    output prio_req,
`endif
    input  req_ready, res_valid, res_id, res_p
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
`ifdef CNN_MUL_SHARE_ARB_PRIO_EN
    input  prio_req,
`endif
    output req_ready, res_valid, res_id, res_p
  );
endinterface

// File: rtl/cnn_mul_share_dsp.sv
// Two-register multiply stage: operand register (s1) then product register
// (s2), both advancing together on en. Maps onto one DSP48 with AREG/PREG.
module cnn_mul_share_dsp
  import cnn_mul_share_pkg::*;
#(
  parameter int ID_W = 2
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  en,
  input  logic                  in_valid,
  input  logic [A_W-1:0]        in_a,
  input  logic [B_W-1:0]        in_b,
  input  logic [ID_W-1:0]       in_id,
  output logic                  out_valid,
  output logic [ID_W-1:0]       out_id,
  output logic signed [P_W-1:0] out_p
);
  logic                  s1_valid;
  logic signed [A_W-1:0] s1_a;
  logic signed [B_W-1:0] s1_b;
  logic [ID_W-1:0]       s1_id;

  // Valid bits: cleared by reset, a bubble enters s1 when nothing is granted.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
    end
  end

  // Data path: operands captured on a grant, full-width signed product next.
  always_ff @(posedge ap_clk) begin
    if (en && in_valid) begin
      s1_a  <= $signed(in_a);
      s1_b  <= $signed(in_b);
      s1_id <= in_id;
    end
    if (en && s1_valid) begin
      out_p  <= s1_a * s1_b;
      out_id <= s1_id;
    end
  end
endmodule

// File: rtl/cnn_mul_share_arb.sv
// Round-robin arbiter in front of one shared 14x8 signed multiplier, with a
// tagged, back-pressured result port.
// Optional feature macro: CNN_MUL_SHARE_ARB_PRIO_EN grants PRIO_IDX first
// while prio_req is high, without moving the round-robin pointer.
module cnn_mul_share_arb
  import cnn_mul_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
`ifdef CNN_MUL_SHARE_ARB_PRIO_EN
  , parameter int PRIO_IDX = 0
`endif
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  cnn_mul_share_arb_if.slave  bus,
  output logic [ID_W-1:0]     dbg_rr_ptr
);
  logic [ID_W-1:0]       rr_ptr;
  logic                  stall;
  logic [MAX_REQ-1:0]    valid_ext;
  pick_t                 pick;
  logic                  prio_hit;
  logic                  grant_any;
  logic [ID_W-1:0]       grant_id;
  logic [A_W-1:0]        grant_a;
  logic [B_W-1:0]        grant_b;
  logic                  s2_valid;
  logic [ID_W-1:0]       s2_id;
  logic signed [P_W-1:0] s2_p;

  assign stall      = s2_valid && !bus.res_ready;
  assign dbg_rr_ptr = rr_ptr;

  // Arbitration: priority override (if built in), else round-robin from rr_ptr.
  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = bus.req_valid;
    pick                     = rr_pick(valid_ext, PICK_W'(rr_ptr), NUM_REQ);
    prio_hit                 = 1'b0;
`ifdef CNN_MUL_SHARE_ARB_PRIO_EN
    prio_hit                 = bus.prio_req && bus.req_valid[PRIO_IDX] && !stall;
    grant_id                 = prio_hit ? ID_W'(PRIO_IDX) : ID_W'(pick.idx);
`else
    grant_id                 = ID_W'(pick.idx);
`endif
    grant_any                = !stall && (pick.found || prio_hit);
    bus.req_ready            = '0;
    if (grant_any) bus.req_ready[grant_id] = 1'b1;
    grant_a                  = bus.req_a[grant_id*A_W +: A_W];
    grant_b                  = bus.req_b[grant_id*B_W +: B_W];
  end

  // Pointer moves past a round-robin winner; priority grants leave it alone.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rr_ptr <= '0;
    end else if (grant_any && !prio_hit) begin
      rr_ptr <= (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  cnn_mul_share_dsp #(.ID_W(ID_W)) u_dsp (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .en        (!stall),
    .in_valid  (grant_any),
    .in_a      (grant_a),
    .in_b      (grant_b),
    .in_id     (grant_id),
    .out_valid (s2_valid),
    .out_id    (s2_id),
    .out_p     (s2_p)
  );

  // Result port reads zero whenever nothing valid is presented.
  always_comb begin
    bus.res_valid = s2_valid;
    bus.res_id    = s2_valid ? s2_id : '0;
    bus.res_p     = s2_valid ? s2_p  : '0;
  end
endmodule

// File: tb/tb_cnn_mul_share_arb.sv
// Bench for cnn_mul_share_arb: vector table for single products, scripted
// sequences for round-robin order, stall, mid-flight reset and priority
// (CNN_MUL_SHARE_ARB_PRIO_EN), with an in-order result scoreboard.
module tb_cnn_mul_share_arb;
  import cnn_mul_share_pkg::*;

  localparam int NR    = 4;
  localparam int IW    = 2;
  localparam int RES_W = IW + P_W;

  typedef struct {
    int id;
    int a;
    int b;
    int exp_p;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [IW-1:0] dbg_rr_ptr;
  int errors = 0;
  int checks = 0;
  logic [RES_W-1:0] exp_q[$];
  int grant_log[$];
  logic signed [P_W-1:0] mon_a, mon_b, mon_p;
  logic [RES_W-1:0] mon_e;
  logic [RES_W-1:0] head_e;
  vec_t vecs[6];

  // Clock and reset
  always #5 clk = ~clk;

  cnn_mul_share_arb_if #(.NUM_REQ(NR), .ID_W(IW)) bus();

  cnn_mul_share_arb #(
    .NUM_REQ (NR),
    .ID_W    (IW)
`ifdef CNN_MUL_SHARE_ARB_PRIO_EN
    , .PRIO_IDX(2)
`endif
  ) dut (
    .ap_clk     (clk),
    .ap_rst     (rst),
    .bus        (bus),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [NR-1:0] v);
    bus.req_valid = v;
    for (int i = 0; i < NR; i++) begin
      bus.req_a[i*A_W +: A_W] = A_W'($urandom_range(0, (1 << A_W) - 1));
      bus.req_b[i*B_W +: B_W] = B_W'($urandom_range(0, (1 << B_W) - 1));
    end
  endtask

  task automatic drain();
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !bus.res_valid) break;
      tick();
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Scoreboard: push on each request handshake, pop on each accepted result
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_onehot", ($countones(bus.req_ready) <= 1), 1);
      for (int i = 0; i < NR; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          mon_a = $signed(bus.req_a[i*A_W +: A_W]);
          mon_b = $signed(bus.req_b[i*B_W +: B_W]);
          mon_p = mon_a * mon_b;
          exp_q.push_back({IW'(i), mon_p});
          grant_log.push_back(i);
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        check("result_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("sb_id", bus.res_id, mon_e[RES_W-1 -: IW]);
          check("sb_p", longint'($signed(bus.res_p)), longint'($signed(mon_e[P_W-1:0])));
        end
      end
    end
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0,   100,   -3,     -300};
    vecs[1] = '{1, -8192, -128,  1048576};
    vecs[2] = '{2,  8191,  127,  1040257};
    vecs[3] = '{3, -8192,  127, -1040384};
    vecs[4] = '{1,    -1,   -1,        1};
    vecs[5] = '{3,     0, -128,        0};

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
`ifdef CNN_MUL_SHARE_ARB_PRIO_EN
    bus.prio_req  = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_res_p", bus.res_p, 0);
    check("rst_res_id", bus.res_id, 0);
    check("rst_rr_ptr", dbg_rr_ptr, 0);
    tick();

    // Table: one requester at a time, exact product and 2-cycle latency
    foreach (vecs[k]) begin
      bus.req_valid = '0;
      bus.req_valid[vecs[k].id] = 1'b1;
      bus.req_a[vecs[k].id*A_W +: A_W] = A_W'(vecs[k].a);
      bus.req_b[vecs[k].id*B_W +: B_W] = B_W'(vecs[k].b);
      @(negedge clk);
      check("tbl_ready", bus.req_ready, 1 << vecs[k].id);
      tick();
      bus.req_valid = '0;
      @(negedge clk);
      check("tbl_early_valid", bus.res_valid, 0);
      tick();
      @(negedge clk);
      check("tbl_res_valid", bus.res_valid, 1);
      check("tbl_res_id", bus.res_id, vecs[k].id);
      check("tbl_res_p", longint'($signed(bus.res_p)), vecs[k].exp_p);
      tick();
    end
    drain();

    // All requesters valid: last table grant was id 3, so order restarts at 0
    grant_log.delete();
    for (int c = 0; c < 12; c++) begin
      set_req(4'hF);
      tick();
    end
    drain();
    check("rr_count", grant_log.size(), 12);
    for (int k = 0; k < grant_log.size(); k++) check("rr_order", grant_log[k], k % NR);
    check("rr_ptr_after", dbg_rr_ptr, 0);

    // Stall: fill the pipe, hold res_ready low for 5 cycles
    for (int c = 0; c < 3; c++) begin
      set_req(4'hF);
      tick();
    end
    bus.res_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_req_ready", bus.req_ready, 0);
      check("stall_res_valid", bus.res_valid, 1);
      check("stall_rr_ptr", dbg_rr_ptr, 3);
      check("stall_q_level", exp_q.size(), 2);
      if (exp_q.size() > 0) begin
        head_e = exp_q[0];
        check("stall_res_id", bus.res_id, head_e[RES_W-1 -: IW]);
        check("stall_res_p", longint'($signed(bus.res_p)), longint'($signed(head_e[P_W-1:0])));
      end
      tick();
    end
    bus.res_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_req(4'hF);
      tick();
    end
    drain();

    // Reset with two products in flight
    for (int c = 0; c < 3; c++) begin
      set_req(4'hF);
      tick();
    end
    check("inflight_before_rst", exp_q.size(), 2);
    rst = 1'b1;
    bus.req_valid = '0;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mrst_res_valid", bus.res_valid, 0);
    check("mrst_rr_ptr", dbg_rr_ptr, 0);
    check("mrst_req_ready", bus.req_ready, 0);
    tick();
    set_req(4'b1010);
    @(negedge clk);
    check("mrst_first_grant", bus.req_ready, 4'b0010);
    tick();
    drain();

`ifdef CNN_MUL_SHARE_ARB_PRIO_EN
    // Move the pointer to 0 (grant 3), then priority to requester 2
    set_req(4'b1000);
    tick();
    drain();
    grant_log.delete();
    bus.prio_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      set_req(4'hF);
      tick();
    end
    check("prio_rr_ptr_held", dbg_rr_ptr, 0);
    bus.prio_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      set_req(4'hF);
      tick();
    end
    drain();
    check("prio_count", grant_log.size(), 8);
    for (int k = 0; k < grant_log.size(); k++) begin
      if (k < 6) check("prio_grant", grant_log[k], 2);
      else       check("prio_resume", grant_log[k], k - 6);
    end
`endif

    // Final report
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
